// File: rtl/load_store_unit_if.sv
// Core-side request/response and data-memory signals of the load/store unit.
// slave is the unit itself; master is its environment (core plus memory).
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_read_data;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned,
        input  req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_write_data, mem_write, mem_read
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned,
        output req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_write_data, mem_write, mem_read
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: drives a word-wide data memory, extracts and extends
// sub-word loads, and performs byte/half stores as read-modify-write.
module load_store_unit #(
    parameter int DEPTH_WORDS = 16,
    parameter bit BIG_ENDIAN  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic        r_uns;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic [15:0] r_wdata;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_mem_read;
    logic        w_mem_write;
    logic [31:0] w_mem_addr;
    logic [31:0] w_mem_wdata;
    logic [31:0] w_rdata;
    logic        w_err;
    logic        w_req_err;
    logic        w_sw;
    logic [4:0]  w_shift;
    logic [31:0] w_lmask;
    logic [31:0] w_lane;
    logic [31:0] w_ext;
    logic [31:0] w_merged;

    assign w_req_err = (bus.req_size == 2'b11)
        || (bus.req_size == 2'b01 && bus.req_addr[0])
        || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
        || ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH_WORDS));

    assign w_sw = r_we && (r_size == 2'b10);

    // Lane position within the word depends on the endianness mapping.
    always_comb begin
        w_shift = 5'd0;
        w_lmask = 32'hFFFF_FFFF;
        if (r_size == 2'b00) begin
            w_shift = BIG_ENDIAN ? {~r_off, 3'b000} : {r_off, 3'b000};
            w_lmask = 32'h0000_00FF;
        end else if (r_size == 2'b01) begin
            w_shift = BIG_ENDIAN ? {~r_off[1], 4'b0000} : {r_off[1], 4'b0000};
            w_lmask = 32'h0000_FFFF;
        end
    end

    assign w_lane = (bus.mem_read_data >> w_shift) & w_lmask;

    always_comb begin
        w_ext = w_lane;
        unique case (1'b1)
            (r_size == 2'b00): w_ext = {{24{~r_uns & w_lane[7]}}, w_lane[7:0]};
            (r_size == 2'b01): w_ext = {{16{~r_uns & w_lane[15]}}, w_lane[15:0]};
            default:           w_ext = w_lane;
        endcase
    end

    assign w_merged = (bus.mem_read_data & ~(w_lmask << w_shift))
        | (({16'h0000, r_wdata} & w_lmask) << w_shift);

    always_comb begin
        w_next      = r_state;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_rdata     = 32'h0;
        w_err       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (w_req_err) begin
                        w_next = RESP;
                        w_err  = 1'b1;
                    end else begin
                        w_next     = ACCESS;
                        w_mem_addr = {2'b00, bus.req_addr[31:2]};
                        if (bus.req_we && bus.req_size == 2'b10) begin
                            w_mem_write = 1'b1;
                            w_mem_wdata = bus.req_wdata;
                        end else begin
                            w_mem_read = 1'b1;
                        end
                    end
                end
            end
            ACCESS: begin
                if (w_sw) begin
                    w_next = RESP;
                end else if (r_we) begin
                    w_next      = WRITE;
                    w_mem_write = 1'b1;
                    w_mem_wdata = w_merged;
                end else begin
                    w_next  = RESP;
                    w_rdata = w_ext;
                end
            end
            WRITE:   w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_uns       <= 1'b0;
            r_size      <= 2'b00;
            r_off       <= 2'b00;
            r_wdata     <= 16'h0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_rdata     <= 32'h0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_mem_read  <= w_mem_read;
            r_mem_write <= w_mem_write;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_rdata     <= w_rdata;
            r_err       <= w_err;
            if (r_state == IDLE && bus.req_valid) begin
                r_we    <= bus.req_we;
                r_uns   <= bus.req_unsigned;
                r_size  <= bus.req_size;
                r_off   <= bus.req_addr[1:0];
                r_wdata <= bus.req_wdata[15:0];
            end
        end
    end

    assign bus.req_ready      = (r_state == IDLE);
    assign bus.resp_valid     = (r_state == RESP);
    assign bus.resp_rdata     = r_rdata;
    assign bus.resp_err       = r_err;
    assign bus.mem_addr       = r_mem_addr;
    assign bus.mem_write_data = r_mem_wdata;
    assign bus.mem_write      = r_mem_write;
    assign bus.mem_read       = r_mem_read;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a 16-word data memory
// preloaded with word i = 5*(i+1).
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit #(.DEPTH_WORDS(16), .BIG_ENDIAN(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [0:15];
    assign bus.mem_read_data = mem[bus.mem_addr[3:0]];
    always @(posedge clk)
        if (bus.mem_write) mem[bus.mem_addr[3:0]] <= bus.mem_write_data;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          nrd;
        int          nwr;
        int          rd_cyc;
        int          wr_cyc;
        logic [31:0] rd_addr;
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
        logic        both;
    } obs_t;

    exp_t sb[$];
    int   ncmp = 0;
    int   nerr = 0;

    // Drives one request, then records the memory activity and response
    // per cycle after the accept edge (cycle 1 is the first cycle after).
    task automatic do_req(input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a,
                          input logic [31:0] wd, output obs_t o);
        int w;
        o = '{default: '0};
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        w = 0;
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.mem_read && bus.mem_write) o.both = 1'b1;
            if (bus.mem_read) begin
                o.nrd++;
                o.rd_cyc  = k;
                o.rd_addr = bus.mem_addr;
            end
            if (bus.mem_write) begin
                o.nwr++;
                o.wr_cyc  = k;
                o.wr_addr = bus.mem_addr;
                o.wr_data = bus.mem_write_data;
            end
            if (bus.resp_valid) begin
                o.lat   = k;
                o.rdata = bus.resp_rdata;
                o.err   = bus.resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        ncmp++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 ||
            bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'h0) begin
            nerr++;
            $display("FAIL reset_resp: ready=%b valid=%b err=%b rdata=%h required 1 0 0 0",
                     bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata);
        end
        ncmp++;
        if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 ||
            bus.mem_addr !== 32'h0 || bus.mem_write_data !== 32'h0) begin
            nerr++;
            $display("FAIL reset_mem: rd=%b wr=%b addr=%h wdata=%h required all 0",
                     bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_write_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_load_word();
        obs_t o;
        exp_t e;
        sb.push_back('{2, 32'h0000_000F, 1'b0});
        do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, o);
        e = sb.pop_front();
        ncmp++;
        if (o.lat !== e.lat || o.rdata !== e.rdata || o.err !== e.err) begin
            nerr++;
            $display("FAIL lw8_resp: lat=%0d rdata=%h err=%b required lat=%0d rdata=%h err=%b",
                     o.lat, o.rdata, o.err, e.lat, e.rdata, e.err);
        end
        ncmp++;
        if (o.nrd !== 1 || o.rd_cyc !== 1 || o.rd_addr !== 32'd2 || o.nwr !== 0) begin
            nerr++;
            $display("FAIL lw8_mem: nrd=%0d rd_cyc=%0d addr=%h nwr=%0d required 1 1 2 0",
                     o.nrd, o.rd_cyc, o.rd_addr, o.nwr);
        end
    endtask

    task automatic test_byte_store();
        obs_t o;
        exp_t e;
        logic [1:0]  sz [4] = '{2'b00, 2'b00, 2'b10, 2'b00};
        logic        un [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] ad [4] = '{32'h9, 32'h9, 32'h8, 32'hB};
        logic [31:0] ex [4] = '{32'hFFFF_FFAB, 32'h0000_00AB,
                                32'h0000_AB0F, 32'h0000_0000};
        sb.push_back('{3, 32'h0, 1'b0});
        do_req(1'b1, 2'b00, 1'b0, 32'h9, 32'h0000_00AB, o);
        e = sb.pop_front();
        ncmp++;
        if (o.lat !== e.lat || o.rdata !== e.rdata || o.err !== e.err) begin
            nerr++;
            $display("FAIL sb9_resp: lat=%0d rdata=%h err=%b required lat=%0d rdata=%h err=%b",
                     o.lat, o.rdata, o.err, e.lat, e.rdata, e.err);
        end
        ncmp++;
        if (o.nrd !== 1 || o.rd_cyc !== 1 || o.rd_addr !== 32'd2 ||
            o.nwr !== 1 || o.wr_cyc !== 2 || o.wr_addr !== 32'd2 ||
            o.wr_data !== 32'h0000_AB0F || o.both !== 1'b0) begin
            nerr++;
            $display("FAIL sb9_mem: rd=%0d@%0d a=%h wr=%0d@%0d a=%h d=%h both=%b required 1@1 2 1@2 2 0000ab0f 0",
                     o.nrd, o.rd_cyc, o.rd_addr, o.nwr, o.wr_cyc, o.wr_addr, o.wr_data, o.both);
        end
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{2, ex[i], 1'b0});
            do_req(1'b0, sz[i], un[i], ad[i], 32'h0, o);
            e = sb.pop_front();
            ncmp++;
            if (o.lat !== e.lat || o.rdata !== e.rdata || o.err !== e.err || o.nwr !== 0) begin
                nerr++;
                $display("FAIL sb_follow%0d: lat=%0d rdata=%h err=%b nwr=%0d required lat=%0d rdata=%h err=%b nwr=0",
                         i, o.lat, o.rdata, o.err, o.nwr, e.lat, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_reset_midop();
        obs_t o;
        exp_t e;
        int   nw = 0;
        int   nv = 0;
        logic rdy;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_size     = 2'b01;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h4;
        bus.req_wdata    = 32'h0000_BEEF;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        rdy = bus.req_ready;
        for (int k = 0; k < 5; k++) begin
            if (bus.mem_write) nw++;
            if (bus.resp_valid) nv++;
            @(negedge clk);
        end
        ncmp++;
        if (rdy !== 1'b1 || nw !== 0 || nv !== 0) begin
            nerr++;
            $display("FAIL rst_midop: ready=%b writes=%0d resps=%0d required 1 0 0",
                     rdy, nw, nv);
        end
        sb.push_back('{2, 32'h0000_000A, 1'b0});
        do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, o);
        e = sb.pop_front();
        ncmp++;
        if (o.lat !== e.lat || o.rdata !== e.rdata || o.err !== e.err) begin
            nerr++;
            $display("FAIL rst_word1: lat=%0d rdata=%h err=%b required lat=%0d rdata=%h err=%b",
                     o.lat, o.rdata, o.err, e.lat, e.rdata, e.err);
        end
    endtask

    task automatic test_half();
        obs_t o;
        exp_t e;
        logic [1:0]  sz [4] = '{2'b01, 2'b01, 2'b10, 2'b01};
        logic        un [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] ad [4] = '{32'h6, 32'h6, 32'h4, 32'h4};
        logic [31:0] ex [4] = '{32'hFFFF_8001, 32'h0000_8001,
                                32'h8001_000A, 32'h0000_000A};
        sb.push_back('{3, 32'h0, 1'b0});
        do_req(1'b1, 2'b01, 1'b0, 32'h6, 32'h1234_8001, o);
        e = sb.pop_front();
        ncmp++;
        if (o.lat !== e.lat || o.err !== e.err || o.nwr !== 1 ||
            o.wr_data !== 32'h8001_000A || o.wr_addr !== 32'd1) begin
            nerr++;
            $display("FAIL sh6: lat=%0d err=%b nwr=%0d a=%h d=%h required 3 0 1 1 8001000a",
                     o.lat, o.err, o.nwr, o.wr_addr, o.wr_data);
        end
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{2, ex[i], 1'b0});
            do_req(1'b0, sz[i], un[i], ad[i], 32'h0, o);
            e = sb.pop_front();
            ncmp++;
            if (o.lat !== e.lat || o.rdata !== e.rdata || o.err !== e.err) begin
                nerr++;
                $display("FAIL sh_follow%0d: lat=%0d rdata=%h err=%b required lat=%0d rdata=%h err=%b",
                         i, o.lat, o.rdata, o.err, e.lat, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_errors();
        obs_t o;
        exp_t e;
        logic        we [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  sz [4] = '{2'b10, 2'b01, 2'b10, 2'b11};
        logic [31:0] ad [4] = '{32'h6, 32'h3, 32'h40, 32'h0};
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{1, 32'h0, 1'b1});
            do_req(we[i], sz[i], 1'b0, ad[i], 32'hFFFF_FFFF, o);
            e = sb.pop_front();
            ncmp++;
            if (o.lat !== e.lat || o.rdata !== e.rdata || o.err !== e.err ||
                o.nrd !== 0 || o.nwr !== 0) begin
                nerr++;
                $display("FAIL err%0d: lat=%0d rdata=%h err=%b nrd=%0d nwr=%0d required lat=%0d rdata=%h err=%b 0 0",
                         i, o.lat, o.rdata, o.err, o.nrd, o.nwr, e.lat, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        obs_t o;
        int   acc [2] = '{-1, -1};
        int   nacc = 0;
        int   nresp = 0;
        int   nwr1 = 0;
        sb.push_back('{0, 32'h0000_0005, 1'b0});
        sb.push_back('{0, 32'h0000_0000, 1'b0});
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        for (int c = 0; c < 20 && nresp < 2; c++) begin
            if (nacc == 1 && c == acc[0] + 1) begin
                bus.req_we    = 1'b1;
                bus.req_addr  = 32'h4;
                bus.req_wdata = 32'hCAFE_0001;
            end
            if (bus.resp_valid) begin
                e = sb.pop_front();
                ncmp++;
                if (bus.resp_rdata !== e.rdata || bus.resp_err !== e.err) begin
                    nerr++;
                    $display("FAIL b2b_resp%0d: rdata=%h err=%b required rdata=%h err=%b",
                             nresp, bus.resp_rdata, bus.resp_err, e.rdata, e.err);
                end
                nresp++;
            end
            if (bus.mem_write && bus.mem_addr == 32'd1) nwr1++;
            if (bus.req_ready && bus.req_valid && nacc < 2) begin
                acc[nacc] = c;
                nacc++;
            end
            @(posedge clk);
            #1 if (nacc == 2) bus.req_valid = 1'b0;
            @(negedge clk);
        end
        ncmp++;
        if (nresp !== 2 || acc[1] - acc[0] !== 3) begin
            nerr++;
            $display("FAIL b2b_timing: resps=%0d accept gap=%0d required 2 3",
                     nresp, acc[1] - acc[0]);
        end
        ncmp++;
        if (nwr1 !== 1) begin
            nerr++;
            $display("FAIL b2b_writes: writes to word1=%0d required 1", nwr1);
        end
        sb.push_back('{2, 32'hCAFE_0001, 1'b0});
        do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, o);
        e = sb.pop_front();
        ncmp++;
        if (o.lat !== e.lat || o.rdata !== e.rdata || o.err !== e.err) begin
            nerr++;
            $display("FAIL b2b_word1: lat=%0d rdata=%h err=%b required lat=%0d rdata=%h err=%b",
                     o.lat, o.rdata, o.err, e.lat, e.rdata, e.err);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'(5 * (i + 1));
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        test_reset();
        test_load_word();
        test_byte_store();
        test_reset_midop();
        test_half();
        test_errors();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts one load/store request at a time from the core.
- Converts byte addresses to word indices and drives the word-wide data memory's addr/write_data/mem_write/mem_read.
- Extracts and sign- or zero-extends sub-word load data.
- Implements SB/SH as read-modify-write, because the memory only writes full words.
- Sits between the execute stage and the data memory; it replaces the direct core-to-memory hookup.

Parameters:
- DEPTH_WORDS, default 16: number of 32-bit words in the data memory. A word index >= DEPTH_WORDS is an access error.
- BIG_ENDIAN, default 0: selects the byte-lane mapping. 0 = byte offset 0 is bits [7:0]. 1 = byte offset 0 is bits [31:24]. Half-words follow the same rule.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; equals (state==IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low bits used for byte and half stores.
- resp_valid  out  1  one-cycle pulse; response fields are valid.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal-size request.
- mem_addr  out  32  word index to the data memory = req_addr[31:2].
- mem_write_data  out  32  full word to write.
- mem_write  out  1  write strobe to the data memory.
- mem_read  out  1  read enable to the data memory.
- mem_read_data  in  32  combinational read data from the data memory.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to IDLE.
  - resp_valid, resp_err, resp_rdata, mem_write, mem_read, mem_addr and mem_write_data all become 0.
  - Any in-flight operation is abandoned: no further mem_write is issued and no response is produced.
- mem_* outputs are registered. mem_read and mem_write are each high only in the states listed below, and never high together.
- States and transitions:
  - IDLE: req_ready=1. On req_valid, latch we/size/unsigned/addr/wdata.
    - Error check: size==11, OR (size==01 and addr[0]!=0), OR (size==10 and addr[1:0]!=0), OR addr[31:2] >= DEPTH_WORDS. On error go to RESP with err=1; no memory cycle is ever issued.
    - Otherwise go to ACCESS.
  - ACCESS (one cycle): mem_addr = addr[31:2].
    - Loads and sub-word stores: mem_read=1. mem_read_data is sampled at the end of this cycle.
    - SW: mem_write=1 with mem_write_data=wdata; then go to RESP.
    - Loads: extract the lane selected by addr[1:0] and size, extend per req_unsigned, store in resp_rdata; then go to RESP.
    - SB/SH: merge the sampled word with wdata[7:0] or wdata[15:0] into the selected lane; then go to WRITE.
  - WRITE (one cycle): mem_write=1, same mem_addr, mem_write_data = merged word; then go to RESP.
  - RESP (one cycle): resp_valid=1; then go to IDLE.
    - resp_rdata and resp_err are held only in this cycle and are 0 otherwise.
- Latency from the request-accept edge (cycle 0):
  - error: resp_valid in cycle 1.
  - load or SW: resp_valid in cycle 2.
  - SB/SH: resp_valid in cycle 3.
  - Next request is accepted in the cycle after RESP.
- Each store asserts mem_write for exactly one cycle. mem_addr is stable for the whole ACCESS..WRITE span.
- Sign extension copies bit 7 (byte) or bit 15 (half) of the extracted lane into all upper bits.
- req_valid seen while req_ready=0 is ignored. The requester must hold the request until it sees req_ready=1.
- The unit holds no data between requests; an SB merge always uses the memory value read in that same request.

Test Plan:
- Memory preloaded with word i = 5*(i+1). LW addr 0x8 accepted at cycle 0 → mem_read=1 with mem_addr=2 in cycle 1; resp_valid in cycle 2 with rdata=0x0000000F, err=0.
- SB addr 0x9, wdata 0x000000AB, BIG_ENDIAN=0:
  - cycle 1: mem_read=1, mem_addr=2.
  - cycle 2: single mem_write with data 0x0000AB0F.
  - cycle 3: resp_valid.
  - Follow-up LB addr 0x9 → 0xFFFFFFAB. LBU addr 0x9 → 0x000000AB. LW addr 0x8 → 0x0000AB0F.
- SH addr 0x6, wdata 0x1234_8001 → word 1 becomes 0x8001000A. LH addr 0x6 → 0xFFFF8001. LHU addr 0x6 → 0x00008001.
- Error cases, each giving resp_valid in cycle 1 with err=1 and rdata=0, and mem_read/mem_write never asserted:
  - LW addr 0x6 (misaligned).
  - SH addr 0x3 (misaligned).
  - LW addr 0x40 (word 16, out of range).
  - size=11.
- rst=1 during the ACCESS cycle of SH addr 0x4:
  - mem_write never asserts and word 1 stays 0x0000000A.
  - No resp_valid is produced; req_ready=1 in the cycle after reset.
- req_valid held high with back-to-back LW 0x0 then SW 0x4:
  - second request is accepted only at the cycle after the first RESP.
  - responses arrive in order.
  - exactly one write occurs to word 1.
